div_iter_unit: RTL and testbench
================================

Name: div_iter_unit

Overview:
- Iterative radix-2 restoring divider. Acts as the responder side of the execute-stage divide request: the execute stage issues a start with operands, stalls on busy, and consumes quotient/remainder on done.
- Replaces the 32-deep pipelined divider with one shared datapath. Handles signed and unsigned 32-bit divides with MIPS DIV/DIVU semantics. Supports flush on exception.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  exception flush; aborts any divide in progress
- start  in  1  request; sampled only when ready=1
- signed_op  in  1  1=DIV (signed), 0=DIVU
- dividend  in  WIDTH  X operand, captured on accepted start
- divisor  in  WIDTH  Y operand, captured on accepted start
- ready  out  1  unit idle and able to accept start
- busy  out  1  divide in progress (stall request to pipeline)
- done  out  1  one-cycle pulse: results valid
- quotient  out  WIDTH  to LO; held until next accepted start
- remainder  out  WIDTH  to HI; held until next accepted start
- div0  out  1  divisor was zero; qualified by done, held with results

Behaviour:
- Reset values: ready=1, busy=0, done=0, quotient=0, remainder=0, div0=0, state=IDLE, iteration counter=0.
- States:
  - IDLE: ready=1. start=1 captures |dividend|, |divisor|, and sign flags (q_neg = signed_op & (x[31]^y[31]); r_neg = signed_op & x[31]), clears the partial remainder, loads counter=WIDTH, and moves to CALC.
  - CALC: busy=1. Each cycle: trial = {rem,msb of shifted dividend} - |divisor|; on no borrow, rem=trial and q bit=1; otherwise restore and q bit=0. Counter decrements. At counter==1 the final step executes and the state moves to FIX.
  - FIX: busy=1. Applies two's-complement negation per q_neg/r_neg, registers quotient/remainder/div0, and moves to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. ready=0 in DONE, so start is ignored there.
- Latency: start accepted at edge E0; CALC occupies E1..E32; FIX registers at E33; done is high in the cycle following E33 (34 cycles start-to-done).
- start while busy or in DONE: ignored, with no side effect.
- Divide by zero: iterations still run. Result is quotient=all-ones, remainder=dividend (raw input, sign kept), div0=1. The sign fixup is bypassed for quotient.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, div0=0. No trap.
- Remainder sign always follows the dividend; quotient truncates toward zero.
- flush in any state: next state is IDLE, busy=0, done suppressed, outputs keep their prior values. flush and start in the same cycle: flush wins and start is not accepted.
- rst mid-operation: all state returns to reset values on the next edge.
- Absolute value uses WIDTH-bit negation; 0x80000000 maps to unsigned 0x80000000.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, on an accepted start, if |divisor| > |dividend| (and divisor != 0), go directly to FIX with quotient=0 and remainder=dividend. done then appears 2 cycles after start.
- Undefined: all divides take the full 34-cycle latency. The test bench reads the macro and checks latency accordingly.

Decomposition:
- Shared package (div_pkg) holds:
  - state enum: IDLE, CALC, FIX, DONE
  - WIDTH default
  - constant DIV_LATENCY=WIDTH+2
  - the all-ones div0 quotient constant
- One natural sub-module, div_step: combinational restoring step. Inputs are rem, next dividend bit, and divisor; outputs are new rem and q bit. It is instantiated once in CALC.

Test Plan:
- Unsigned 100/7, signed_op=0 -> done at cycle 34 (2 with DIV_EARLY_OUT_EN only if applicable: not here), quotient=14, remainder=2, div0=0.
- Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
- Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; then unsigned 5/0 -> quotient=0xFFFFFFFF, remainder=5, div0=1.
- Start 1000/3, assert flush at cycle 10 -> busy=0 at cycle 11, no done pulse, outputs unchanged. New start 9/4 at cycle 12 -> quotient=2, remainder=1, 34 cycles later.
- Second start pulsed during CALC with different operands -> ignored; first result delivered unchanged. Early-out 3/10 with macro defined -> done at cycle 2, quotient=0, remainder=3.
- rst asserted at cycle 20 of a divide -> next cycle ready=1, busy=0, quotient=remainder=0, no done.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Used by div_step and div_iter_unit.
package div_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 2;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = {DIV_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract
// the divisor and keep the difference only when it does not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {rem_i, bit_i};
        q_o     = shifted >= {1'b0, dsr_i};
        rem_o   = q_o ? WIDTH'(shifted - {1'b0, dsr_i})
                      : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative signed/unsigned divider, MIPS DIV/DIVU semantics.
// Optional DIV_EARLY_OUT_EN skips iterations when |divisor| > |dividend|.
module div_iter_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             div0_q, div0_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] abs_x, abs_y;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[WIDTH-1]),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        div0_d  = div0_q;

        abs_x = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        abs_y = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = '0;
                    dvd_d   = abs_x;
                    dsr_d   = abs_y;
                    q_neg_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_d = signed_op & dividend[WIDTH-1];
                    zero_d  = (divisor == '0);
                    cnt_d   = CW'(WIDTH);
                    state_d = CALC;
`ifdef DIV_EARLY_OUT_EN
                    // quotient is known zero; remainder is the whole dividend
                    if (abs_y > abs_x) begin
                        rem_d   = abs_x;
                        dvd_d   = '0;
                        state_d = FIX;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                // a zero divisor leaves |x| in rem, so only the quotient is forced
                quot_d  = zero_q  ? DIV0_QUOT : (q_neg_q ? -dvd_q : dvd_q);
                remo_d  = r_neg_q ? -rem_q : rem_q;
                div0_d  = zero_q;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            quot_d  = quot_q;
            remo_d  = remo_q;
            div0_d  = div0_q;
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == CALC) || (state_d == FIX);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            div0_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            div0_q  <= div0_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Randomized and directed bench for div_iter_unit against an
// arithmetic reference model; honours DIV_EARLY_OUT_EN for latency.
module tb_div_iter_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, flush, start, signed_op;
    logic [W-1:0] dividend, divisor;
    logic         ready, busy, done, div0;
    logic [W-1:0] quotient, remainder;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] last_q, last_r;
    logic         last_z;

    div_iter_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic s, input logic [W-1:0] x,
                                  input logic [W-1:0] y,
                                  output logic [W-1:0] q,
                                  output logic [W-1:0] r,
                                  output logic z);
        longint a, b;
        if (s) begin
            a = longint'($signed(x));
            b = longint'($signed(y));
        end else begin
            a = longint'({32'b0, x});
            b = longint'({32'b0, y});
        end
        z = (y == '0);
        if (z) begin
            q = '1;
            r = x;
        end else begin
            q = W'(a / b);
            r = W'(a % b);
        end
    endfunction

    function automatic int exp_lat(input logic s, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
`ifdef DIV_EARLY_OUT_EN
        longint ax, ay;
        ax = s ? longint'($signed(x)) : longint'({32'b0, x});
        ay = s ? longint'($signed(y)) : longint'({32'b0, y});
        if (ax < 0) ax = -ax;
        if (ay < 0) ay = -ay;
        if (ay != 0 && ay > ax) return 2;
`endif
        return 34;
    endfunction

    task automatic run_div(input logic s, input logic [W-1:0] x,
                           input logic [W-1:0] y, input bit junk,
                           input string tag);
        logic [W-1:0] eq, er;
        logic         ez;
        int           lat;
        bit           seen;
        model(s, x, y, eq, er, ez);
        start = 1'b1; signed_op = s; dividend = x; divisor = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        seen = 0;
        check({tag, "/ready_lo"}, ready, 0);
        check({tag, "/busy_hi"}, busy, 1);
        while (!seen && lat < 200) begin
            if (junk && lat == 5) begin
                start = 1'b1; signed_op = ~s;
                dividend = x ^ 32'h5a5a_1234; divisor = y + 3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (done) seen = 1;
        end
        check({tag, "/latency"}, W'(lat), W'(exp_lat(s, x, y)));
        check({tag, "/busy_lo"}, busy, 0);
        check({tag, "/quot"}, quotient, eq);
        check({tag, "/rem"}, remainder, er);
        check({tag, "/div0"}, div0, ez);
        if (junk) begin
            start = 1'b1; signed_op = 1'b0; dividend = 7; divisor = 1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "/done_1cyc"}, done, 0);
        check({tag, "/ready_back"}, ready, 1);
        if (junk) begin
            check({tag, "/done_start_ign"}, busy, 0);
            check({tag, "/quot_held"}, quotient, eq);
        end
        last_q = eq; last_r = er; last_z = ez;
    endtask

    task automatic no_done_for(input int n, input string tag);
        int hits = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done) hits++;
        end
        check(tag, W'(hits), 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; start = 1'b0; signed_op = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst/ready", ready, 1);
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        check("rst/quot", quotient, 0);
        check("rst/rem", remainder, 0);
        check("rst/div0", div0, 0);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 0, "u100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'h2, 0, "s-7_2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "s_ovf");
        run_div(1'b0, 32'd5, 32'd0, 0, "u5_0");
        run_div(1'b1, 32'hFFFF_FFF7, 32'd0, 0, "s-9_0");
        run_div(1'b0, 32'd123456, 32'd789, 1, "junk_start");
        run_div(1'b0, 32'd3, 32'd10, 0, "early_3_10");
        run_div(1'b1, 32'hFFFF_FFFD, 32'd10, 0, "early_s-3_10");

        // flush mid-divide
        start = 1'b1; signed_op = 1'b0; dividend = 1000; divisor = 3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush/busy", busy, 0);
        check("flush/ready", ready, 1);
        check("flush/done", done, 0);
        check("flush/quot", quotient, last_q);
        check("flush/rem", remainder, last_r);
        check("flush/div0", div0, last_z);
        no_done_for(40, "flush/no_done");
        flush = 1'b1; start = 1'b1; dividend = 50; divisor = 5;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        check("flush_start/busy", busy, 0);
        check("flush_start/ready", ready, 1);
        run_div(1'b0, 32'd9, 32'd4, 0, "after_flush");

        // reset mid-divide
        start = 1'b1; signed_op = 1'b1; dividend = 1000; divisor = 3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst/ready", ready, 1);
        check("midrst/busy", busy, 0);
        check("midrst/done", done, 0);
        check("midrst/quot", quotient, 0);
        check("midrst/rem", remainder, 0);
        check("midrst/div0", div0, 0);
        no_done_for(40, "midrst/no_done");

        for (int i = 0; i < 40; i++) begin
            logic         s;
            logic [W-1:0] x, y;
            int           sel;
            s   = 1'($urandom);
            x   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = '0;
            else if (sel <= 3) y = $urandom_range(1, 20);
            else y = $urandom;
            if (sel == 1 && s) y = -y;
            if (sel == 4) x = $urandom_range(0, 50);
            if (sel == 5) begin x = 32'h8000_0000; y = '1; end
            run_div(s, x, y, (i % 5) == 0, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
